// File: rtl/reg_bank_pkg.sv
// Shared definitions for the reg_bank_2r1w register bank.
//   state_t  : bulk-clear sequencer states
//   addr_ok  : true when an index falls inside a bank of num_regs words
package reg_bank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Indices are widened to 32 bits by the caller so one helper serves any
    // address width; needed because NUM_REGS need not be a power of two.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned num_regs);
        return addr < num_regs;
    endfunction

endpackage

// File: rtl/reg_bank_2r1w_word.sv
// One storage word of the register bank.
//   clk, rst : clock, asynchronous active-high reset (word -> 0)
//   load     : capture d on the rising edge
//   clr      : synchronous clear to 0 (takes priority over load)
//   d, q     : write data in, stored word out
module reg_word #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its inputs, independent of block ordering.
    // NOTE: the storage words are reset here on purpose: the bank must read
    // zero after reset, so this memory cannot be left to a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank_2r1w.sv
// Parametrised register bank: NUM_REGS words of DATA_WIDTH bits, one write
// port, two registered read ports with write-to-read bypass, and a sequenced
// bulk clear (one word per cycle while busy is high).
//   clk, rst               : clock, asynchronous active-high reset
//   wr_en, wr_addr, Din    : write strobe, binary write index, write data
//   rd_en_a/b, rd_addr_a/b : read strobe and index per port
//   q_a, q_b               : registered read data (holds when rd_en is low)
//   clear_req              : start a bulk clear (pulse or level)
//   busy                   : bulk clear in progress
module reg_bank_2r1w
    import reg_bank_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter bit ZERO_REG0  = 1'b0,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] Din,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] q_b,
    input  logic                  clear_req,
    output logic                  busy
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;

    logic [DATA_WIDTH-1:0] words [NUM_REGS];
    logic [NUM_REGS-1:0]   load;
    logic [NUM_REGS-1:0]   clr;
    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] rd_next_a;
    logic [DATA_WIDTH-1:0] rd_next_b;

    // A write is taken only in IDLE, to a real word, not to a hardwired-zero
    // word 0, and never in the same cycle as a clear request.
    assign wr_accept = wr_en
                     && (state == IDLE)
                     && !clear_req
                     && addr_ok(32'(wr_addr), NUM_REGS)
                     && !(ZERO_REG0 && (wr_addr == '0));

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        load = '0;
        clr  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            load[i] = wr_accept && (wr_addr == ADDR_WIDTH'(i));
            clr[i]  = (state == CLEAR) && (cnt == ADDR_WIDTH'(i));
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        reg_word #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_word (
            .clk (clk),
            .rst (rst),
            .load(load[i]),
            .clr (clr[i]),
            .d   (Din),
            .q   (words[i])
        );
    end

    // Read muxes: an index that matches no word yields 0, which covers
    // out-of-range addresses. The bypass sits last so an accepted write to
    // the same index wins; dropped writes never reach it via wr_accept.
    always_comb begin
        rd_next_a = '0;
        rd_next_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == ADDR_WIDTH'(i)) rd_next_a = words[i];
            if (rd_addr_b == ADDR_WIDTH'(i)) rd_next_b = words[i];
        end
        if (ZERO_REG0 && (rd_addr_a == '0)) rd_next_a = '0;
        if (ZERO_REG0 && (rd_addr_b == '0)) rd_next_b = '0;
        if (wr_accept && (wr_addr == rd_addr_a)) rd_next_a = Din;
        if (wr_accept && (wr_addr == rd_addr_b)) rd_next_b = Din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (rd_en_a) q_a <= rd_next_a;
            if (rd_en_b) q_b <= rd_next_b;
        end
    end

    // Bulk-clear sequencer: cnt names the word cleared on the next edge;
    // the edge that clears the last word returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == ADDR_WIDTH'(NUM_REGS - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_2r1w.sv
// Self-checking bench for reg_bank_2r1w: a default 16x32 instance (m_*) and
// a 12-word instance with hardwired-zero word 0 (z_*).
module tb_reg_bank_2r1w;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        m_wr_en, m_rd_en_a, m_rd_en_b, m_clear_req, m_busy;
    logic [3:0]  m_wr_addr, m_rd_addr_a, m_rd_addr_b;
    logic [31:0] m_din, m_q_a, m_q_b;

    logic        z_wr_en, z_rd_en_a, z_rd_en_b, z_clear_req, z_busy;
    logic [3:0]  z_wr_addr, z_rd_addr_a, z_rd_addr_b;
    logic [31:0] z_din, z_q_a, z_q_b;

    reg_bank_2r1w u_main (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (m_wr_en),
        .wr_addr  (m_wr_addr),
        .Din      (m_din),
        .rd_en_a  (m_rd_en_a),
        .rd_addr_a(m_rd_addr_a),
        .rd_en_b  (m_rd_en_b),
        .rd_addr_b(m_rd_addr_b),
        .q_a      (m_q_a),
        .q_b      (m_q_b),
        .clear_req(m_clear_req),
        .busy     (m_busy)
    );

    reg_bank_2r1w #(
        .DATA_WIDTH(32),
        .NUM_REGS  (12),
        .ZERO_REG0 (1'b1)
    ) u_zero (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (z_wr_en),
        .wr_addr  (z_wr_addr),
        .Din      (z_din),
        .rd_en_a  (z_rd_en_a),
        .rd_addr_a(z_rd_addr_a),
        .rd_en_b  (z_rd_en_b),
        .rd_addr_b(z_rd_addr_b),
        .q_a      (z_q_a),
        .q_b      (z_q_b),
        .clear_req(z_clear_req),
        .busy     (z_busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [31:0] din;
        logic        rd_en_a;
        logic [3:0]  rd_addr_a;
        logic        rd_en_b;
        logic [3:0]  rd_addr_b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Edge, then sample 1 time unit later, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_idle();
        m_wr_en = 0; m_wr_addr = 0; m_din = 0;
        m_rd_en_a = 0; m_rd_addr_a = 0; m_rd_en_b = 0; m_rd_addr_b = 0;
        m_clear_req = 0;
    endtask

    task automatic z_idle();
        z_wr_en = 0; z_wr_addr = 0; z_din = 0;
        z_rd_en_a = 0; z_rd_addr_a = 0; z_rd_en_b = 0; z_rd_addr_b = 0;
        z_clear_req = 0;
    endtask

    task automatic m_write(input logic [3:0] addr, input logic [31:0] data);
        m_idle();
        m_wr_en = 1; m_wr_addr = addr; m_din = data;
        tick();
    endtask

    task automatic m_read(input logic [3:0] addr_a, input logic [3:0] addr_b);
        m_idle();
        m_rd_en_a = 1; m_rd_addr_a = addr_a;
        m_rd_en_b = 1; m_rd_addr_b = addr_b;
        tick();
    endtask

    task automatic z_write(input logic [3:0] addr, input logic [31:0] data);
        z_idle();
        z_wr_en = 1; z_wr_addr = addr; z_din = data;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_cycles;
        logic [31:0] exp;

        //                 wr  addr  din           rdA addrA rdB addrB exp_a         exp_b
        vecs[0] = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd0, 32'h00000000, 32'h00000000};
        vecs[1] = '{1'b0, 4'd0, 32'h00000000, 1'b1, 4'd5, 1'b1, 4'd6, 32'hDEADBEEF, 32'h00000000};
        vecs[2] = '{1'b1, 4'd3, 32'h12345678, 1'b1, 4'd3, 1'b1, 4'd3, 32'h12345678, 32'h12345678};
        vecs[3] = '{1'b0, 4'd0, 32'h00000000, 1'b0, 4'd9, 1'b1, 4'd5, 32'h12345678, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 4'd5, 32'h11111111, 1'b1, 4'd5, 1'b1, 4'd3, 32'h11111111, 32'h12345678};
        vecs[5] = '{1'b0, 4'd0, 32'h00000000, 1'b1, 4'd5, 1'b1, 4'd0, 32'h11111111, 32'h00000000};

        m_idle();
        z_idle();
        rst = 1;
        repeat (2) tick();
        rst = 0;
        check("reset_busy_main", 32'(m_busy), 32'd0);
        check("reset_busy_zero", 32'(z_busy), 32'd0);

        // Every word reads zero after reset, on both ports.
        for (int i = 0; i < 16; i++) begin
            m_read(4'(i), 4'(15 - i));
            check($sformatf("reset_rd_a%0d", i), m_q_a, 32'h0);
            check($sformatf("reset_rd_b%0d", 15 - i), m_q_b, 32'h0);
        end

        // Directed vectors: write/read, bypass, read-enable hold.
        for (int i = 0; i < 6; i++) begin
            m_idle();
            m_wr_en = vecs[i].wr_en; m_wr_addr = vecs[i].wr_addr; m_din = vecs[i].din;
            m_rd_en_a = vecs[i].rd_en_a; m_rd_addr_a = vecs[i].rd_addr_a;
            m_rd_en_b = vecs[i].rd_en_b; m_rd_addr_b = vecs[i].rd_addr_b;
            tick();
            check($sformatf("vec%0d_q_a", i), m_q_a, vecs[i].exp_a);
            check($sformatf("vec%0d_q_b", i), m_q_b, vecs[i].exp_b);
        end

        // Bulk clear of a fully populated bank.
        for (int i = 0; i < 16; i++) m_write(4'(i), 32'hA5A5A5A5);
        m_idle();
        m_clear_req = 1;
        tick();
        check("clr_busy_rise", 32'(m_busy), 32'd1);
        busy_cycles = 1;
        for (int k = 1; k <= 40; k++) begin
            if (!m_busy) break;
            m_idle();
            if (k == 1) begin
                // Dropped write; word 0 is being cleared this edge and still
                // reads its old value; word 15 is untouched so far.
                m_wr_en = 1; m_wr_addr = 4'd2; m_din = 32'hDEAD0002;
                m_rd_en_a = 1; m_rd_addr_a = 4'd15;
                m_rd_en_b = 1; m_rd_addr_b = 4'd0;
            end
            if (k == 2) begin
                m_rd_en_a = 1; m_rd_addr_a = 4'd2;
                m_rd_en_b = 1; m_rd_addr_b = 4'd0;
            end
            if (k == 3) m_clear_req = 1;
            tick();
            if (k == 1) begin
                check("clr_mid_rd15", m_q_a, 32'hA5A5A5A5);
                check("clr_mid_rd0_old", m_q_b, 32'hA5A5A5A5);
            end
            if (k == 2) begin
                check("clr_wr_dropped", m_q_a, 32'hA5A5A5A5);
                check("clr_rd0_cleared", m_q_b, 32'h0);
            end
            if (m_busy) busy_cycles++;
        end
        check("clr_busy_cycles", 32'(busy_cycles), 32'd16);
        check("clr_busy_fall", 32'(m_busy), 32'd0);

        // First edge with busy low accepts a write.
        m_write(4'd4, 32'hCAFE0004);
        for (int i = 0; i < 16; i++) begin
            m_read(4'(i), 4'(i));
            exp = (i == 4) ? 32'hCAFE0004 : 32'h0;
            check($sformatf("clr_after_a%0d", i), m_q_a, exp);
            check($sformatf("clr_after_b%0d", i), m_q_b, exp);
        end

        // Reset during the 5th busy cycle.
        m_write(4'd7, 32'h77777777);
        m_write(4'd12, 32'h0000000C);
        m_read(4'd7, 4'd12);
        check("pre_rst_q_a", m_q_a, 32'h77777777);
        m_idle();
        m_clear_req = 1;
        tick();
        m_idle();
        repeat (4) tick();
        check("rst_mid_busy_before", 32'(m_busy), 32'd1);
        #2;
        rst = 1;
        #1;
        check("rst_async_busy", 32'(m_busy), 32'd0);
        check("rst_async_q_a", m_q_a, 32'h0);
        check("rst_async_q_b", m_q_b, 32'h0);
        tick();
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            m_read(4'(i), 4'(15 - i));
            check($sformatf("rst_clr_a%0d", i), m_q_a, 32'h0);
            check($sformatf("rst_clr_b%0d", 15 - i), m_q_b, 32'h0);
        end
        check("rst_busy_stays_low", 32'(m_busy), 32'd0);
        m_write(4'd7, 32'h0000BEEF);
        m_read(4'd7, 4'd7);
        check("rst_then_rw_a", m_q_a, 32'h0000BEEF);
        check("rst_then_rw_b", m_q_b, 32'h0000BEEF);

        // Hardwired-zero word 0 and out-of-range writes on the 12-word bank.
        for (int i = 1; i < 12; i++) z_write(4'(i), 32'h01010101 * 32'(i));
        z_idle();
        z_wr_en = 1; z_wr_addr = 4'd0; z_din = 32'hFFFFFFFF;
        z_rd_en_a = 1; z_rd_addr_a = 4'd0;
        tick();
        check("z_wr0_no_bypass", z_q_a, 32'h0);
        z_idle();
        z_wr_en = 1; z_wr_addr = 4'd13; z_din = 32'hFFFFFFFF;
        z_rd_en_b = 1; z_rd_addr_b = 4'd13;
        tick();
        check("z_wr13_no_bypass", z_q_b, 32'h0);
        for (int i = 0; i < 12; i++) begin
            z_idle();
            z_rd_en_a = 1; z_rd_addr_a = 4'(i);
            z_rd_en_b = 1; z_rd_addr_b = 4'(11 - i);
            tick();
            check($sformatf("z_rd_a%0d", i), z_q_a, (i == 0) ? 32'h0 : 32'h01010101 * 32'(i));
            check($sformatf("z_rd_b%0d", 11 - i), z_q_b,
                  (i == 11) ? 32'h0 : 32'h01010101 * 32'(11 - i));
        end
        z_idle();
        z_rd_en_a = 1; z_rd_addr_a = 4'd13;
        z_rd_en_b = 1; z_rd_addr_b = 4'd12;
        tick();
        check("z_rd13", z_q_a, 32'h0);
        check("z_rd12", z_q_b, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
